// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder: picorv32 memory slave with wait states, byte-masked writes and a sticky error flag; MEMRESP_RANDOM_WAIT_EN adds LFSR-based random wait states.
module picorv32_mem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [4:0] cnt, wc;
  logic [31:0] addr_q, wdata_q, a_addr, a_wdata, off;
  logic [3:0] wstrb_q, a_wstrb;
  logic viol, acc, ok;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic unused_ok;
  assign unused_ok = mem_instr;
`ifdef MEMRESP_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    if (reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign wc = 5'(WAIT_CYCLES) + {2'b00, lfsr[2:0]};
`else
  assign wc = 5'(WAIT_CYCLES);
`endif
  assign mem_ready = state == RESP;
  // In IDLE a zero-wait request is served straight from the live bus; otherwise from the latched copy.
  always_comb begin
    viol = state == WAIT && (!mem_valid || mem_addr != addr_q || mem_wdata != wdata_q || mem_wstrb != wstrb_q);
    a_addr = state == IDLE ? mem_addr : addr_q;
    a_wdata = state == IDLE ? mem_wdata : wdata_q;
    a_wstrb = state == IDLE ? mem_wstrb : wstrb_q;
    acc = !reset && ((state == IDLE && mem_valid && wc == 5'd0) || (state == WAIT && !viol && cnt == 5'd1));
    off = a_addr - BASE_ADDR;
    ok = off[1:0] == 2'b00 && (off[31:2] >> ADDR_WIDTH) == 30'd0;
    idx = off[ADDR_WIDTH+1:2];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (acc && ok && a_wstrb[i]) mem[idx][8*i+:8] <= a_wdata[8*i+:8];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 5'd0;
      mem_rdata <= 32'h0;
      err <= 1'b0;
      addr_q <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
    end else begin
      if (acc) mem_rdata <= (ok && a_wstrb == 4'h0) ? mem[idx] : 32'h0;
      if ((acc && !ok) || viol) err <= 1'b1;
      if (state == IDLE && mem_valid) begin
        addr_q <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        cnt <= wc;
        state <= wc == 5'd0 ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt <= viol ? 5'd0 : cnt - 5'd1;
        state <= viol ? IDLE : cnt == 5'd1 ? RESP : WAIT;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// tb_picorv32_mem_responder: three responders (0, 3 and 5 wait states) exercised by directed and shadow-model transactions.
module tb_picorv32_mem_responder;
`ifdef MEMRESP_RANDOM_WAIT_EN
  localparam int RMAX = 7;
`else
  localparam int RMAX = 0;
`endif
  logic clk = 0, reset = 1;
  logic [2:0] v = 3'b000, rdy, er;
  logic [2:0][31:0] rd;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0] wstrb = 0;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  picorv32_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .mem_valid(v[0]), .mem_instr(1'b0), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy[0]), .mem_rdata(rd[0]), .err(er[0]));
  picorv32_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .mem_valid(v[1]), .mem_instr(1'b1), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy[1]), .mem_rdata(rd[1]), .err(er[1]));
  picorv32_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(5)) u5 (
    .clk(clk), .reset(reset), .mem_valid(v[2]), .mem_instr(1'b0), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy[2]), .mem_rdata(rd[2]), .err(er[2]));

  function automatic int wof(input int d);
    return d == 0 ? 0 : d == 1 ? 3 : 5;
  endfunction

  // One full transaction on responder d; lat counts cycles from accept edge to the ready cycle (0 on timeout).
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] r, output int lat);
    @(negedge clk);
    addr = a; wdata = wd; wstrb = ws; v[d] = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!rdy[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rdy[d]) lat = 0;
    r = rd[d];
    v[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (rdy !== 3'b000 || er !== 3'b000 || rd[0] !== 32'h0 || rd[1] !== 32'h0 || rd[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b err=%b rdata0=%h rdata1=%h rdata2=%h, required all zero", rdy, er, rd[0], rd[1], rd[2]);
    end
  endtask

  task automatic test_write_read;
    logic [31:0] r; int lat;
    xact(0, 32'h10, 32'hDEADBEEF, 4'hF, r, lat);
    n_checks++;
    if (lat < 1 || lat > 1 + RMAX) begin n_fail++; $display("FAIL wr_latency: got %0d, required 1..%0d", lat, 1 + RMAX); end
    xact(0, 32'h10, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h, required deadbeef", r); end
    n_checks++;
    if (lat < 1 || lat > 1 + RMAX) begin n_fail++; $display("FAIL rd_latency: got %0d, required 1..%0d", lat, 1 + RMAX); end
  endtask

  task automatic test_byte_mask;
    logic [31:0] r; int lat;
    xact(0, 32'h20, 32'h11223344, 4'hF, r, lat);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL write_rdata_zero: got %h, required 00000000", r); end
    xact(0, 32'h20, 32'hAABBCCDD, 4'b0101, r, lat);
    xact(0, 32'h20, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (r !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_mask: got %h, required 11bb33dd", r); end
  endtask

  task automatic test_wait3;
    logic [31:0] r; int lat;
    xact(1, 32'h40, 32'h0BADCAFE, 4'hF, r, lat);
    @(negedge clk);
    addr = 32'h40; wdata = 0; wstrb = 0; v[1] = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!rdy[1] && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat < 4 || lat > 4 + RMAX) begin n_fail++; $display("FAIL wait3_latency: got %0d, required 4..%0d", lat, 4 + RMAX); end
    n_checks++;
    if (rd[1] !== 32'h0BADCAFE) begin n_fail++; $display("FAIL wait3_data: got %h, required 0badcafe", rd[1]); end
    v[1] = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL ready_one_cycle: got %b, required 0", rdy[1]); end
  endtask

  task automatic test_bad_req;
    logic [31:0] r; int lat;
    xact(1, 32'h0, 32'hCAFEF00D, 4'hF, r, lat);
    xact(1, 32'h10, 32'h01020304, 4'hF, r, lat);
    n_checks++;
    if (er[1] !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b, required 0", er[1]); end
    xact(1, 32'h12, 32'hFFFFFFFF, 4'hF, r, lat);
    n_checks++;
    if (lat == 0 || er[1] !== 1'b1) begin n_fail++; $display("FAIL misaligned_wr: lat=%0d err=%b, required acked and err 1", lat, er[1]); end
    xact(1, 32'h0, 32'h0, 4'h0, r, lat);
    xact(1, 32'h1002, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (lat == 0 || r !== 32'h0 || er[1] !== 1'b1) begin n_fail++; $display("FAIL misaligned_rd: lat=%0d rdata=%h err=%b, required acked 00000000 1", lat, r, er[1]); end
    xact(1, 32'h1000, 32'h55555555, 4'hF, r, lat);
    n_checks++;
    if (lat == 0 || er[1] !== 1'b1) begin n_fail++; $display("FAIL range_wr: lat=%0d err=%b, required acked and err 1", lat, er[1]); end
    xact(1, 32'h0, 32'h0, 4'h0, r, lat);
    xact(1, 32'h1000, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (lat == 0 || r !== 32'h0) begin n_fail++; $display("FAIL range_rd: lat=%0d rdata=%h, required acked 00000000", lat, r); end
    xact(1, 32'h10, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (r !== 32'h01020304) begin n_fail++; $display("FAIL misaligned_no_write: got %h, required 01020304", r); end
    xact(1, 32'h0, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (r !== 32'hCAFEF00D || er[1] !== 1'b1) begin n_fail++; $display("FAIL range_no_write: rdata=%h err=%b, required cafef00d 1", r, er[1]); end
  endtask

  task automatic test_protocol;
    logic [31:0] r; int lat; bit seen;
    xact(2, 32'h4, 32'h76543210, 4'hF, r, lat);
    @(negedge clk);
    addr = 32'h4; wdata = 0; wstrb = 0; v[2] = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    v[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rdy[2]) seen = 1;
    end
    n_checks++;
    if (seen || er[2] !== 1'b1) begin n_fail++; $display("FAIL protocol_drop: ready_seen=%b err=%b, required 0 1", seen, er[2]); end
    xact(2, 32'h4, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (lat < 6 || lat > 6 + RMAX || r !== 32'h76543210) begin n_fail++; $display("FAIL protocol_recover: lat=%0d rdata=%h, required 6..%0d 76543210", lat, r, 6 + RMAX); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] r; int lat;
    xact(2, 32'h8, 32'h12345678, 4'hF, r, lat);
    @(negedge clk);
    addr = 32'h8; wdata = 32'h99999999; wstrb = 4'hF; v[2] = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rdy[2] !== 1'b0 || er !== 3'b000) begin n_fail++; $display("FAIL reset_in_wait: ready=%b err=%b, required 0 000", rdy[2], er); end
    @(negedge clk);
    reset = 1'b0; v[2] = 1'b0;
    xact(2, 32'h8, 32'h0, 4'h0, r, lat);
    n_checks++;
    if (r !== 32'h12345678) begin n_fail++; $display("FAIL reset_discard: got %h, required 12345678", r); end
  endtask

  task automatic test_random;
    logic [31:0] sh [64];
    logic [31:0] r, d, m; int lat, k; logic [3:0] s;
    for (int i = 0; i < 64; i++) begin
      sh[i] = $urandom;
      xact(0, 32'(i * 4), sh[i], 4'hF, r, lat);
    end
    for (int i = 0; i < 100; i++) begin
      k = $urandom_range(0, 63);
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      xact(0, 32'(k * 4), d, s, r, lat);
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      n_checks++;
      if (r !== (s == 4'h0 ? sh[k] : 32'h0)) begin n_fail++; $display("FAIL random_data[%0d]: got %h, required %h", i, r, s == 4'h0 ? sh[k] : 32'h0); end
      n_checks++;
      if (lat < 1 || lat > 1 + RMAX) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d, required 1..%0d", i, lat, 1 + RMAX); end
      sh[k] = (sh[k] & ~m) | (d & m);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_mask;
    test_wait3;
    test_bad_req;
    test_protocol;
    test_reset_in_wait;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
